// File: rtl/line_memory.sv
// Single-port line memory of DEPTH 256-bit lines with a fixed request-to-ack latency.
// One request in flight at a time; ack_o/data_o are registered one-cycle pulses.
module line_memory #(
   parameter int unsigned LATENCY = 10,
   parameter int unsigned DEPTH   = 512
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [31:0]  addr_i,
   input  logic         enable_i,
   input  logic         write_i,
   input  logic [255:0] data_i,
   output logic         ack_o,
   output logic [255:0] data_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   // BUSY hands over to ACK on the edge where the counter reaches LATENCY-1.
   localparam logic [7:0] CntLast = 8'((LATENCY > 1) ? LATENCY - 2 : 0);

   typedef enum logic [1:0] {StIdle, StBusy, StAck} state_e;

   state_e         state_q;
   logic [7:0]     cnt_q;
   logic [AW-1:0]  idx_q;
   logic           wr_q;
   logic [255:0]   wdata_q;
   logic [255:0]   mem_q [DEPTH];

   logic unused_addr;
   assign unused_addr = ^{addr_i[31:AW+5], addr_i[4:0]};

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         ack_o   <= 1'b0;
         data_o  <= '0;
         idx_q   <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         ack_o  <= 1'b0;
         data_o <= '0;
         unique case (state_q)
            StIdle: begin
               if (enable_i) begin
                  idx_q   <= addr_i[AW+4:5];
                  wr_q    <= write_i;
                  wdata_q <= data_i;
                  cnt_q   <= '0;
                  state_q <= (LATENCY == 1) ? StAck : StBusy;
               end
            end
            StBusy: begin
               cnt_q <= cnt_q + 8'd1;
               if (cnt_q == CntLast) state_q <= StAck;
            end
            StAck: begin
               ack_o   <= 1'b1;
               data_o  <= wr_q ? wdata_q : mem_q[idx_q];
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Contents survive reset; the write lands on the same edge the ack pulse starts.
   always_ff @(posedge clk_i) begin
      if (state_q == StAck && wr_q) mem_q[idx_q] <= wdata_q;
   end

endmodule

// File: doc/line_memory.md
LINE_MEMORY -- requirements
Module: line_memory

Interface
REQ-001 Parameter LATENCY, default 10: cycles from request acceptance to ack_o; legal range 1..255.
REQ-002 Parameter DEPTH, default 512: number of 256-bit lines; power of two.
REQ-003 clk_i  input  1: the block's single clock; all state changes on the rising edge.
REQ-004 rst_i  input  1: asynchronous reset, active-low (0 = reset asserted).
REQ-005 addr_i  input  32: byte address; line index = addr_i[4+log2(DEPTH):5]; addr_i[4:0] and all upper bits are ignored.
REQ-006 enable_i  input  1: request valid.
REQ-007 write_i  input  1: 1 = line write, 0 = line read; sampled with enable_i.
REQ-008 data_i  input  256: write line data.
REQ-009 ack_o  output  1: one-cycle completion pulse.
REQ-010 data_o  output  256: line data, valid only while ack_o=1.

Function
REQ-011 The block SHALL implement the FSM states IDLE, BUSY and ACK.
REQ-012 In IDLE, a rising edge with enable_i=1 SHALL accept the request: capture line index, write_i and data_i, clear the cycle counter, and go to BUSY (or to ACK directly if LATENCY=1).
REQ-013 In BUSY, the counter SHALL increment each cycle; the FSM SHALL go to ACK on the edge at which the counter reaches LATENCY-1.
REQ-014 If a request is accepted at edge N, ack_o SHALL be 1 for exactly the one cycle between edges N+LATENCY and N+LATENCY+1 and 0 at all other times.
REQ-015 For a read, data_o during ack SHALL equal the memory line as it stands at edge N+LATENCY.
REQ-016 For a write, the memory line SHALL be updated at edge N+LATENCY, and data_o during ack SHALL equal the captured write data.
REQ-017 Inputs changing during BUSY or ACK SHALL NOT affect the in-flight request; enable_i SHALL be ignored outside IDLE.
REQ-018 ACK SHALL always return to IDLE after one cycle.
- The earliest next acceptance is edge N+LATENCY+1.
- A requester that holds enable_i high through ack SHALL therefore see a second request accepted.
REQ-019 Index arithmetic SHALL wrap modulo DEPTH; no out-of-range error is signalled.
REQ-020 data_o SHALL be 0 whenever ack_o=0.
REQ-021 Only one request SHALL be in flight at a time; the block has no queueing.

Reset
REQ-022 rst_i=0 SHALL immediately force the following, independent of clk_i: state IDLE, counter 0, ack_o 0, data_o 0.
REQ-023 Reset SHALL NOT clear memory contents.
- A write whose acceptance preceded reset but whose edge N+LATENCY had not occurred SHALL be discarded, with memory unchanged.
REQ-024 After rst_i returns to 1, the first rising edge with enable_i=1 SHALL be accepted as a new request.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Write then read, LATENCY=10: write addr 0x0000_0040, data {8{32'hDEAD_BEEF}} accepted at edge 0 -> ack at edges 10-11. Read of the same address accepted at edge 11 -> ack at edges 21-22 with data_o={8{32'hDEAD_BEEF}}.
- Address aliasing, DEPTH=512: write 0x0000_4020 with data A, then read 0x0000_0020 -> data_o=A. Read 0x0000_0025 -> data_o=A (offset bits ignored).
- Input changes during BUSY: accept a read of line 3, then change addr_i, write_i=1 and data_i every cycle while BUSY -> data_o equals original line 3 and no line is modified.
- Enable held high continuously for 3 reads -> acks at edges 10, 21 and 32. ack_o is never high for two consecutive cycles.
- Reset mid-write: accept a write of line 5 at edge 0, drive rst_i=0 between edges 4 and 5 -> ack_o=0 and data_o=0 immediately, no ack follows, and a later read of line 5 returns the pre-write value.
- LATENCY=1 build: a read accepted at edge N -> ack_o high between edges N+1 and N+2, and the next acceptance occurs at edge N+2.
